// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin byte-serial RAM arbiter for NPORT load/store requesters
module mem_arbiter #(
  parameter int         NPORT  = 3,
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      io_buffer_full,
  input  logic [7:0]                mem_din,
  output logic                      mem_wr,
  output logic [ADDR_W-1:0]         mem_a,
  output logic [7:0]                mem_dout,
  input  logic [NPORT-1:0]          req_valid,
  input  logic [NPORT-1:0]          req_we,
  input  logic [2*NPORT-1:0]        req_len,
  input  logic [NPORT-1:0]          req_sext,
  input  logic [NPORT*ADDR_W-1:0]   req_addr,
  input  logic [NPORT*32-1:0]       req_wdata,
  output logic [NPORT-1:0]          resp_valid,
  output logic [31:0]               resp_rdata,
  output logic [NPORT-1:0]          grant
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       gnt, last, pick;
  logic                found, accept;
  logic                we_r, sext_r;
  logic [1:0]          len_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic [2:0]          cnt, cnt_nx, ofs;
  logic [31:0]         rbuf, rbuf_nx, rdata_nx;
  logic                stall;
  logic [NPORT-1:0]    gnt_oh;

  // Round-robin search starting just after the last granted port.
  always_comb begin
    found = 1'b0;
    pick  = last;
    for (int i = 1; i <= NPORT; i++) begin
      if (!found && req_valid[(int'(last) + i) % NPORT]) begin
        found = 1'b1;
        pick  = PW'((int'(last) + i) % NPORT);
      end
    end
  end

  assign gnt_oh = NPORT'(1) << gnt;
  assign stall  = we_r && io_buffer_full && (addr_r[17:16] == IO_HI);
  // While frozen, keep presenting the previous byte's address so mem_din still holds it.
  assign ofs    = (!rdy && cnt != 3'd0) ? cnt - 3'd1 : cnt;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    rbuf_nx    = rbuf;
    rdata_nx   = resp_rdata;
    accept     = 1'b0;
    mem_wr     = 1'b0;
    mem_a      = '0;
    mem_dout   = '0;
    resp_valid = '0;
    grant      = '0;
    case (state)
      IDLE: begin
        if (rdy && found) begin
          accept   = 1'b1;
          cnt_nx   = 3'd0;
          rbuf_nx  = '0;
          state_nx = req_we[pick] ? WRITE : READ;
        end
      end
      READ: begin
        grant = gnt_oh;
        if (ofs <= {1'b0, len_r})
          mem_a = addr_r + ADDR_W'(ofs);
        if (rdy) begin
          if (!req_valid[gnt]) begin
            state_nx = IDLE;
          end else begin
            if (cnt != 3'd0)
              rbuf_nx[8*(int'(cnt)-1) +: 8] = mem_din;
            cnt_nx = cnt + 3'd1;
            if (cnt == {1'b0, len_r} + 3'd1) begin
              state_nx = RESP;
              case (len_r)
                2'd0:    rdata_nx = {{24{sext_r & rbuf_nx[7]}},  rbuf_nx[7:0]};
                2'd1:    rdata_nx = {{16{sext_r & rbuf_nx[15]}}, rbuf_nx[15:0]};
                default: rdata_nx = rbuf_nx;
              endcase
            end
          end
        end
      end
      WRITE: begin
        grant    = gnt_oh;
        mem_a    = addr_r + ADDR_W'(cnt);
        mem_dout = wdata_r[8*cnt +: 8];
        if (rdy && !stall) begin
          mem_wr = 1'b1;
          cnt_nx = cnt + 3'd1;
          if (cnt == {1'b0, len_r})
            state_nx = RESP;
        end
      end
      RESP: begin
        grant      = gnt_oh;
        resp_valid = gnt_oh;
        if (rdy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      last       <= PW'(NPORT - 1);
      gnt        <= '0;
      rbuf       <= '0;
      resp_rdata <= '0;
      we_r       <= 1'b0;
      sext_r     <= 1'b0;
      len_r      <= 2'd0;
      addr_r     <= '0;
      wdata_r    <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rbuf       <= rbuf_nx;
      resp_rdata <= rdata_nx;
      if (accept) begin
        gnt     <= pick;
        last    <= pick;
        we_r    <= req_we[pick];
        sext_r  <= req_sext[pick];
        // A 3-byte request is carried out as a full word.
        len_r   <= (req_len[2*pick +: 2] == 2'd2) ? 2'd3 : req_len[2*pick +: 2];
        addr_r  <= req_addr[ADDR_W*pick +: ADDR_W];
        wdata_r <= req_wdata[32*pick +: 32];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int NPORT = 3;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst, rdy, io_buffer_full;
  logic [7:0] mem_din;
  logic mem_wr;
  logic [ADDR_W-1:0] mem_a;
  logic [7:0] mem_dout;
  logic [NPORT-1:0] req_valid, req_we, req_sext;
  logic [2*NPORT-1:0] req_len;
  logic [NPORT*ADDR_W-1:0] req_addr;
  logic [NPORT*32-1:0] req_wdata;
  logic [NPORT-1:0] resp_valid, grant;
  logic [31:0] resp_rdata;

  int n_assert = 0;
  int n_fail = 0;
  int resp_cnt = 0;
  logic [7:0] ram [0:262143];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  int order[$];
  int exp_ord[4] = '{0, 1, 2, 0};

  mem_arbiter #(.NPORT(NPORT), .ADDR_W(ADDR_W), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout),
    .req_valid(req_valid), .req_we(req_we), .req_len(req_len), .req_sext(req_sext),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  // RAM with one cycle read latency plus a log of every byte written.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[17:0]];
    if (mem_wr) begin
      ram[mem_a[17:0]] = mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
    if (resp_valid != 0) resp_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int p, input logic [1:0] len, input logic sx,
                         input logic [31:0] a, input logic [31:0] exp, input int lat,
                         input string tag);
    int n;
    req_we[p] = 1'b0;
    req_len[2*p +: 2] = len;
    req_sext[p] = sx;
    req_addr[32*p +: 32] = a;
    req_valid[p] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (resp_valid == 0 && n < 40);
    chk({tag, " latency"}, n, lat);
    chk({tag, " resp_valid"}, resp_valid, 3'b001 << p);
    chk({tag, " rdata"}, resp_rdata, exp);
    req_valid[p] = 1'b0;
    tick();
    chk({tag, " grant idle"}, grant, 0);
  endtask

  initial begin
    int n, low, dropped;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h11; ram[18'h101] = 8'h22; ram[18'h102] = 8'h33; ram[18'h103] = 8'h44;
    ram[18'h200] = 8'h80;
    ram[18'h300] = 8'h34; ram[18'h301] = 8'h92;
    rst = 1'b1; rdy = 1'b1; io_buffer_full = 1'b0;
    req_valid = '0; req_we = '0; req_len = '0; req_sext = '0; req_addr = '0; req_wdata = '0;
    tick(); tick();
    chk("reset grant", grant, 0);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset mem_wr", mem_wr, 0);
    chk("reset mem_a", mem_a, 0);
    chk("reset mem_dout", mem_dout, 0);
    chk("reset rdata", resp_rdata, 0);
    rst = 1'b0;
    tick();

    // Port1 4-byte load, address walk and latency.
    req_len[3:2] = 2'd3; req_addr[63:32] = 32'h100; req_valid[1] = 1'b1;
    tick();
    chk("w4 grant", grant, 3'b010);
    chk("w4 a0", mem_a, 32'h100);
    tick(); chk("w4 a1", mem_a, 32'h101);
    tick(); chk("w4 a2", mem_a, 32'h102);
    tick(); chk("w4 a3", mem_a, 32'h103);
    chk("w4 rd mem_wr", mem_wr, 0);
    tick(); chk("w4 no resp yet", resp_valid, 0);
    tick();
    chk("w4 resp_valid", resp_valid, 3'b010);
    chk("w4 rdata", resp_rdata, 32'h44332211);
    chk("w4 resp mem_a", mem_a, 0);
    req_valid[1] = 1'b0;
    tick();
    chk("w4 idle grant", grant, 0);
    chk("w4 rdata stable", resp_rdata, 32'h44332211);

    do_load(0, 2'd0, 1'b1, 32'h200, 32'hFFFFFF80, 3, "b sext");
    do_load(0, 2'd0, 1'b0, 32'h200, 32'h00000080, 3, "b zext");
    do_load(0, 2'd1, 1'b1, 32'h300, 32'hFFFF9234, 4, "h sext");
    do_load(2, 2'd2, 1'b0, 32'h100, 32'h44332211, 6, "len2 as 4");

    // Abort during READ: no response.
    resp_cnt = 0;
    req_we[1] = 1'b0; req_len[3:2] = 2'd3; req_addr[63:32] = 32'h100; req_valid[1] = 1'b1;
    tick(); tick();
    req_valid[1] = 1'b0;
    tick();
    chk("abort grant", grant, 0);
    tick(); tick();
    chk("abort no resp", resp_cnt, 0);

    // Fairness with all ports requesting from reset.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int p = 0; p < 3; p++) begin
      req_len[2*p +: 2] = 2'd0; req_addr[32*p +: 32] = 32'h200; req_sext[p] = 1'b0;
    end
    req_valid = 3'b111;
    dropped = -1; n = 0;
    while (order.size() < 4 && n < 80) begin
      tick(); n++;
      if (resp_valid != 0) begin
        for (int p = 0; p < 3; p++)
          if (resp_valid[p]) begin order.push_back(p); req_valid[p] = 1'b0; dropped = p; end
      end else if (dropped >= 0) begin
        req_valid[dropped] = 1'b1; dropped = -1;
      end
    end
    req_valid = '0;
    chk("rr count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) chk($sformatf("rr order %0d", i), order[i], exp_ord[i]);
    tick(); tick();

    // Port2 store to the IO region with a 3-cycle buffer-full stall.
    wlog_a.delete(); wlog_d.delete(); resp_cnt = 0;
    req_we[2] = 1'b1; req_len[5:4] = 2'd3; req_addr[95:64] = 32'h30000;
    req_wdata[95:64] = 32'hDEADBEEF; req_valid[2] = 1'b1;
    tick();
    chk("st grant", grant, 3'b100);
    chk("st b0 wr", mem_wr, 1);
    chk("st b0 a", mem_a, 32'h30000);
    chk("st b0 d", mem_dout, 8'hEF);
    tick(); chk("st b1 a", mem_a, 32'h30001); chk("st b1 d", mem_dout, 8'hBE);
    tick();
    io_buffer_full = 1'b1;
    low = 0;
    repeat (3) begin
      #1;
      if (!mem_wr && mem_a == 32'h30002) low++;
      tick();
    end
    io_buffer_full = 1'b0;
    #1;
    chk("st stall cycles", low, 3);
    chk("st b2 wr", mem_wr, 1);
    chk("st b2 a", mem_a, 32'h30002);
    chk("st b2 d", mem_dout, 8'hAD);
    tick(); chk("st b3 a", mem_a, 32'h30003); chk("st b3 d", mem_dout, 8'hDE);
    tick(); chk("st resp_valid", resp_valid, 3'b100);
    chk("st resp mem_wr", mem_wr, 0);
    req_valid[2] = 1'b0; req_we[2] = 1'b0;
    tick(); tick();
    chk("st single resp", resp_cnt, 1);
    chk("st write count", wlog_d.size(), 4);
    if (wlog_d.size() == 4) begin
      chk("st order 0", {wlog_a[0], wlog_d[0]}, {32'h30000, 8'hEF});
      chk("st order 1", {wlog_a[1], wlog_d[1]}, {32'h30001, 8'hBE});
      chk("st order 2", {wlog_a[2], wlog_d[2]}, {32'h30002, 8'hAD});
      chk("st order 3", {wlog_a[3], wlog_d[3]}, {32'h30003, 8'hDE});
    end

    // Loads ignore the IO buffer-full flag.
    io_buffer_full = 1'b1;
    do_load(0, 2'd0, 1'b1, 32'h30001, 32'hFFFFFFBE, 3, "io load");
    io_buffer_full = 1'b0;

    // Reset in the middle of a READ.
    req_we[1] = 1'b0; req_len[3:2] = 2'd3; req_addr[63:32] = 32'h100; req_valid[1] = 1'b1;
    tick(); tick(); tick();
    chk("rst mid a", mem_a, 32'h102);
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid[1] = 1'b0;
    chk("rst mid grant", grant, 0);
    chk("rst mid mem_a", mem_a, 0);
    chk("rst mid resp", resp_valid, 0);
    chk("rst mid rdata", resp_rdata, 0);
    chk("rst mid mem_wr", mem_wr, 0);
    do_load(0, 2'd0, 1'b0, 32'h200, 32'h00000080, 3, "post rst");

    // rdy toggling every cycle during a 2-byte load.
    req_len[1:0] = 2'd1; req_sext[0] = 1'b0; req_addr[31:0] = 32'h300; req_we[0] = 1'b0;
    req_valid[0] = 1'b1; rdy = 1'b1; n = 0;
    do begin
      tick(); n++;
      if (resp_valid == 0) rdy = ~rdy;
    end while (resp_valid == 0 && n < 40);
    rdy = 1'b1;
    chk("rdy tog resp", resp_valid, 3'b001);
    chk("rdy tog rdata", resp_rdata, 32'h00009234);
    req_valid[0] = 1'b0;
    tick();
    chk("rdy tog idle", grant, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
